// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one completed functional-unit result per cycle
// with rotating priority, and filters speculative results on branch flush/commit.
module cdb_arbiter #(
  parameter int NUM_UNIT          = 4,
  parameter int BW_TAG            = 4,
  parameter int BW_PROCESSOR_DATA = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_UNIT-1:0]                   i_req_valid,
  output logic [NUM_UNIT-1:0]                   o_req_ready,
  input  logic [NUM_UNIT*BW_TAG-1:0]            i_req_tag_flatten,
  input  logic [NUM_UNIT*BW_PROCESSOR_DATA-1:0] i_req_data_flatten,
  input  logic [NUM_UNIT-1:0]                   i_req_speculation,
  input  logic                                  i_branch_valid,
  input  logic                                  i_branch_flush,
  output logic                                  o_cdb_valid,
  output logic [BW_TAG-1:0]                     o_cdb_tag,
  output logic [BW_PROCESSOR_DATA-1:0]          o_cdb_data,
  output logic                                  o_cdb_speculation,
  output logic [$clog2(NUM_UNIT)-1:0]           o_rr_ptr
);

  localparam int PW = $clog2(NUM_UNIT);

  logic [BW_TAG-1:0]            req_tag  [NUM_UNIT];
  logic [BW_PROCESSOR_DATA-1:0] req_data [NUM_UNIT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNIT; gi++) begin : g_unpack
      assign req_tag[gi]  = i_req_tag_flatten[gi*BW_TAG +: BW_TAG];
      assign req_data[gi] = i_req_data_flatten[gi*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
    end
  endgenerate

  logic                         flush;
  logic                         commit;
  logic [NUM_UNIT-1:0]          squash;
  logic [NUM_UNIT-1:0]          cand;
  logic                         found;
  logic [PW-1:0]                winner;
  logic [NUM_UNIT-1:0]          grant_onehot;
  logic [PW-1:0]                rr_ptr_reg, rr_ptr_next;
  logic                         cdb_valid_reg;
  logic [BW_TAG-1:0]            cdb_tag_reg;
  logic [BW_PROCESSOR_DATA-1:0] cdb_data_reg;
  logic                         cdb_spec_reg;
  int                           idx;

  assign flush  = i_branch_valid & i_branch_flush;
  assign commit = i_branch_valid & ~i_branch_flush;
  // On a flush, speculative requests are swallowed rather than competing for the bus.
  assign squash = i_req_valid & i_req_speculation & {NUM_UNIT{flush}};
  assign cand   = i_req_valid & ~squash;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_UNIT; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NUM_UNIT) idx = idx - NUM_UNIT;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (found) grant_onehot[winner] = 1'b1;
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (found) rr_ptr_next = (winner == PW'(NUM_UNIT-1)) ? '0 : winner + PW'(1);
  end

  assign o_req_ready = rst_n ? (grant_onehot | squash) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_reg <= 1'b0;
      cdb_tag_reg   <= '0;
      cdb_data_reg  <= '0;
      cdb_spec_reg  <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      cdb_valid_reg <= found;
      rr_ptr_reg    <= rr_ptr_next;
      if (found) begin
        cdb_tag_reg  <= req_tag[winner];
        cdb_data_reg <= req_data[winner];
        cdb_spec_reg <= i_req_speculation[winner] & ~commit;
      end
    end
  end

  assign o_cdb_valid       = cdb_valid_reg;
  assign o_cdb_tag         = cdb_tag_reg;
  assign o_cdb_data        = cdb_data_reg;
  assign o_cdb_speculation = cdb_spec_reg;
  assign o_rr_ptr          = rr_ptr_reg;

`ifndef SYNTHESIS
  // Tag 0 means "no producer", so a valid result carrying it is a requester bug.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < NUM_UNIT; u++) begin
        if (i_req_valid[u]) assert (req_tag[u] != '0);
        for (int v = u + 1; v < NUM_UNIT; v++) begin
          if (i_req_valid[u] && i_req_valid[v] && req_tag[u] != '0)
            assert (req_tag[u] != req_tag[v]);
        end
      end
      if (!flush) assert ($onehot0(o_req_ready));
    end
  end
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among the four functional units: INT, MUL, BRANCH and LOAD_STORE.
- Each cycle it grants at most one completed result, using rotating round-robin priority, and drives the grant onto a registered broadcast bus.
- Reservation stations and the register file snoop that bus to wake up operands waiting on Q tags.
- It also applies branch-flush and commit semantics to speculative results, so squashed work never broadcasts.

Parameters:
- NUM_UNIT, 4, number of requesters; index order follows the unit encoding: INT, MUL, BRANCH, LOAD_STORE.
- BW_TAG, 4, width of a rename tag; tag 0 means "value ready / no producer".
- BW_PROCESSOR_DATA, 32, result width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_req_valid  input  NUM_UNIT  per-unit result valid
- o_req_ready  output  NUM_UNIT  per-unit grant; a handshake is valid&ready
- i_req_tag_flatten  input  NUM_UNIT*BW_TAG  unit u's tag in bits [u*BW_TAG +: BW_TAG]
- i_req_data_flatten  input  NUM_UNIT*BW_PROCESSOR_DATA  unit u's result, packed the same way
- i_req_speculation  input  NUM_UNIT  result was issued under an unresolved branch
- i_branch_valid  input  1  branch resolution event this cycle
- i_branch_flush  input  1  qualifies i_branch_valid; 1 = mispredict, 0 = correct prediction
- o_cdb_valid  output  1  broadcast valid
- o_cdb_tag  output  BW_TAG  broadcast tag
- o_cdb_data  output  BW_PROCESSOR_DATA  broadcast value
- o_cdb_speculation  output  1  broadcast value is still speculative
- o_rr_ptr  output  log2(NUM_UNIT)  current highest-priority unit (debug/verification)

Behaviour:
Reset values:
- o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_speculation=0, o_rr_ptr=0, o_req_ready=0.

Handshake:
- The CDB has no backpressure; the output register loads every cycle.
- o_req_ready is combinational from i_req_valid, the speculation bits, flush and the pointer.
  - At most one bit of o_req_ready is high, except during a flush (see below).
  - o_req_ready[u] is never high unless i_req_valid[u] is high.
- A requester holds valid, tag, data and speculation stable until its handshake.
- Valid may not drop without a handshake, except speculative requests on a flush cycle.

Arbitration:
- Scan units from o_rr_ptr upward, modulo NUM_UNIT; the first valid candidate wins.
- Next cycle: o_rr_ptr = (winner+1) mod NUM_UNIT. With no grant, o_rr_ptr holds.
- Latency: a handshake in cycle N appears on o_cdb_* in cycle N+1.
- Cycles with no grant produce o_cdb_valid=0 and leave tag/data/speculation unchanged.

Flush (i_branch_valid && i_branch_flush in cycle N):
- Every unit with i_req_valid && i_req_speculation gets o_req_ready=1 in cycle N. These requests are consumed and discarded.
- Arbitration in cycle N considers only non-speculative requesters. Their winner broadcasts in N+1.
- If the output register currently holds a speculative result, it is NOT visible in N+1; o_cdb_valid=0 unless a non-speculative winner loads.
- o_rr_ptr advances only on a non-speculative grant.

Commit (i_branch_valid && !i_branch_flush in cycle N):
- The winner of cycle N broadcasts with o_cdb_speculation=0.
- An in-flight register value keeps its broadcast unchanged. This is a single speculation level.

Protocol checks:
- A valid request with tag 0 is a protocol error. An assertion in the RTL flags it; the request is still arbitrated normally.
- Two units presenting the same nonzero tag simultaneously is an error, asserted in simulation only.

Reset mid-operation:
- Asynchronous reset returns to the reset values immediately. Pending requests are not remembered.

Test Plan:
- After reset, raise all 4 valids with tags 1,2,3,4 and hold them → grants in order unit0, 1, 2, 3. o_cdb_tag = 1,2,3,4 on cycles 1..4 after the first grant. o_rr_ptr = 1,2,3,0.
- Only unit2 valid (tag 5, data 0xDEADBEEF), o_rr_ptr=0 → o_req_ready=4'b0100 the same cycle. Next cycle o_cdb_valid=1, tag=5, data=0xDEADBEEF. o_rr_ptr becomes 3.
- Unit1 speculative (tag 6) and unit3 non-speculative (tag 7) both valid, flush asserted, o_rr_ptr=1 → o_req_ready=4'b1010. Next cycle o_cdb_tag=7, o_cdb_speculation=0. Tag 6 never appears.
- Speculative tag 8 granted in cycle N, flush in cycle N with no other requesters → cycle N+1 has o_cdb_valid=0 and tag 8 never broadcasts.
- Speculative unit0 tag 9 granted together with commit → o_cdb_valid=1, tag=9, o_cdb_speculation=0 next cycle.
- Assert rst_n low while unit3 holds the bus with o_cdb_valid=1 → outputs go to reset values immediately. After release, the first grant goes to the lowest valid unit from ptr 0.
